// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Hazard/flow controller for a fetch/decode/execute pipeline.
//            Detects load-use hazards (decode reads a register that a load in
//            execute is about to write) and holds fetch/decode while inserting
//            bubbles; flushes younger stages on a taken branch/jump resolved in
//            execute; freezes the pipe while data memory is busy. Keeps
//            saturating stall-cycle and taken-jump counters.
// Ports    : clk, rst_n (async, active-low)
//            id_*   : decode-stage instruction valid and source registers
//            ex_*   : execute-stage load/write-back info and jump resolution
//            mem_busy_in, perf_clr_in
//            pc_hold_out, if_id_hold_out, if_id_flush_out, id_ex_bubble_out,
//            ex_mem_hold_out, jump_en_out, jump_addr_out : same-cycle controls
//            state_out, stall_cycles_out, flush_count_out : status/perf
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 2,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_instr_valid_in,
  input  logic [4:0]       id_reg1_addr_in,
  input  logic [4:0]       id_reg2_addr_in,
  input  logic             ex_is_load_in,
  input  logic             ex_wen_in,
  input  logic [4:0]       ex_write_addr_in,
  input  logic             ex_jump_en_in,
  input  logic [31:0]      ex_jump_addr_in,
  input  logic             mem_busy_in,
  input  logic             perf_clr_in,
  output logic             pc_hold_out,
  output logic             if_id_hold_out,
  output logic             if_id_flush_out,
  output logic             id_ex_bubble_out,
  output logic             ex_mem_hold_out,
  output logic             jump_en_out,
  output logic [31:0]      jump_addr_out,
  output logic [1:0]       state_out,
  output logic [CNT_W-1:0] stall_cycles_out,
  output logic [CNT_W-1:0] flush_count_out
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    MEM_WAIT   = 2'd3
  } state_t;

  localparam logic [3:0] LOAD_RELOAD  = 4'(LOAD_STALL_CYCLES - 1);
  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

  state_t           state, state_nxt, ret_state, ret_nxt, active;
  logic [3:0]       cnt, cnt_nxt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, stall_nxt, flush_nxt;
  logic             hazard;
  logic             pc_hold, if_id_hold, if_id_flush, id_ex_bubble, ex_mem_hold;
  logic             jump_en;
  logic [31:0]      jump_addr;

  assign hazard = id_instr_valid_in & ex_is_load_in & ex_wen_in &
                  (ex_write_addr_in != 5'd0) &
                  (((id_reg1_addr_in == ex_write_addr_in) && (id_reg1_addr_in != 5'd0)) ||
                   ((id_reg2_addr_in == ex_write_addr_in) && (id_reg2_addr_in != 5'd0)));

  // On the first idle-memory cycle the saved state is resumed in that same
  // cycle, so the decision logic always works on the "effective" state.
  assign active = (state == MEM_WAIT) ? ret_state : state;

  always_comb begin
    pc_hold      = 1'b0;
    if_id_hold   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_hold  = 1'b0;
    jump_en      = 1'b0;
    jump_addr    = 32'd0;
    state_nxt    = state;
    ret_nxt      = ret_state;
    cnt_nxt      = cnt;
    if (mem_busy_in) begin
      pc_hold     = 1'b1;
      if_id_hold  = 1'b1;
      ex_mem_hold = 1'b1;
      state_nxt   = MEM_WAIT;
      // Capture the interrupted state only on entry; cnt stays frozen.
      if (state != MEM_WAIT) ret_nxt = state;
    end else if (ex_jump_en_in) begin
      jump_en      = 1'b1;
      jump_addr    = ex_jump_addr_in;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      ret_nxt      = RUN;
      if (FLUSH_CYCLES > 1) begin
        state_nxt = FLUSH;
        cnt_nxt   = FLUSH_RELOAD;
      end else begin
        state_nxt = RUN;
        cnt_nxt   = 4'd0;
      end
    end else begin
      ret_nxt = RUN;
      case (active)
        LOAD_STALL: begin
          pc_hold      = 1'b1;
          if_id_hold   = 1'b1;
          id_ex_bubble = 1'b1;
          if (cnt <= 4'd1) begin
            state_nxt = RUN;
            cnt_nxt   = 4'd0;
          end else begin
            state_nxt = LOAD_STALL;
            cnt_nxt   = cnt - 4'd1;
          end
        end
        FLUSH: begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          if (cnt <= 4'd1) begin
            state_nxt = RUN;
            cnt_nxt   = 4'd0;
          end else begin
            state_nxt = FLUSH;
            cnt_nxt   = cnt - 4'd1;
          end
        end
        default: begin
          // Hazards start a stall only from RUN; inside a stall the outputs
          // already match, and inside a flush decode holds a dead instruction.
          state_nxt = RUN;
          cnt_nxt   = 4'd0;
          if (hazard) begin
            pc_hold      = 1'b1;
            if_id_hold   = 1'b1;
            id_ex_bubble = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_nxt = LOAD_STALL;
              cnt_nxt   = LOAD_RELOAD;
            end
          end
        end
      endcase
    end
  end

  // Clear wins over increment; both counters stop at all-ones.
  always_comb begin
    stall_nxt = stall_cnt;
    flush_nxt = flush_cnt;
    if (perf_clr_in) begin
      stall_nxt = '0;
      flush_nxt = '0;
    end else begin
      if (pc_hold && (stall_cnt != {CNT_W{1'b1}})) stall_nxt = stall_cnt + CNT_W'(1);
      if (jump_en && (flush_cnt != {CNT_W{1'b1}})) flush_nxt = flush_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      ret_state <= RUN;
      cnt       <= 4'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      ret_state <= ret_nxt;
      cnt       <= cnt_nxt;
      stall_cnt <= stall_nxt;
      flush_cnt <= flush_nxt;
    end
  end

  // Controls are combinational, so they are gated to keep the pipe quiet
  // for as long as reset is held.
  assign pc_hold_out      = rst_n & pc_hold;
  assign if_id_hold_out   = rst_n & if_id_hold;
  assign if_id_flush_out  = rst_n & if_id_flush;
  assign id_ex_bubble_out = rst_n & id_ex_bubble;
  assign ex_mem_hold_out  = rst_n & ex_mem_hold;
  assign jump_en_out      = rst_n & jump_en;
  assign jump_addr_out    = rst_n ? jump_addr : 32'd0;
  assign state_out        = state;
  assign stall_cycles_out = stall_cnt;
  assign flush_count_out  = flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Purpose  : Self-checking bench. Two controllers share one stimulus stream:
//            dut_a (1 stall cycle, 2 flush cycles, 16-bit counters) and
//            dut_b (3 stall cycles, 2 flush cycles, 8-bit counters). A model
//            tracking "remaining stall/flush cycles" predicts every output on
//            every cycle; directed literal checks pin key results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        id_valid;
  logic [4:0]  r1, r2, wa;
  logic        ld, wen, jmp, busy, clr;
  logic [31:0] jaddr;

  logic        a_pch, a_ifh, a_iff, a_bub, a_exh, a_jen;
  logic [31:0] a_jaddr;
  logic [1:0]  a_st;
  logic [15:0] a_stall, a_flush;
  logic        b_pch, b_ifh, b_iff, b_bub, b_exh, b_jen;
  logic [31:0] b_jaddr;
  logic [1:0]  b_st;
  logic [7:0]  b_stall, b_flush;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_instr_valid_in(id_valid), .id_reg1_addr_in(r1),
    .id_reg2_addr_in(r2), .ex_is_load_in(ld), .ex_wen_in(wen), .ex_write_addr_in(wa),
    .ex_jump_en_in(jmp), .ex_jump_addr_in(jaddr), .mem_busy_in(busy), .perf_clr_in(clr),
    .pc_hold_out(a_pch), .if_id_hold_out(a_ifh), .if_id_flush_out(a_iff),
    .id_ex_bubble_out(a_bub), .ex_mem_hold_out(a_exh), .jump_en_out(a_jen),
    .jump_addr_out(a_jaddr), .state_out(a_st), .stall_cycles_out(a_stall),
    .flush_count_out(a_flush));

  pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_instr_valid_in(id_valid), .id_reg1_addr_in(r1),
    .id_reg2_addr_in(r2), .ex_is_load_in(ld), .ex_wen_in(wen), .ex_write_addr_in(wa),
    .ex_jump_en_in(jmp), .ex_jump_addr_in(jaddr), .mem_busy_in(busy), .perf_clr_in(clr),
    .pc_hold_out(b_pch), .if_id_hold_out(b_ifh), .if_id_flush_out(b_iff),
    .id_ex_bubble_out(b_bub), .ex_mem_hold_out(b_exh), .jump_en_out(b_jen),
    .jump_addr_out(b_jaddr), .state_out(b_st), .stall_cycles_out(b_stall),
    .flush_count_out(b_flush));

  // Per-DUT views: ctl = {pc_hold, if_id_hold, if_id_flush, bubble, ex_mem_hold, jump_en}
  logic [5:0]  o_ctl   [2];
  logic [31:0] o_addr  [2];
  logic [1:0]  o_st    [2];
  logic [15:0] o_stall [2];
  logic [15:0] o_flush [2];
  always_comb begin
    o_ctl[0]   = {a_pch, a_ifh, a_iff, a_bub, a_exh, a_jen};
    o_ctl[1]   = {b_pch, b_ifh, b_iff, b_bub, b_exh, b_jen};
    o_addr[0]  = a_jaddr;
    o_addr[1]  = b_jaddr;
    o_st[0]    = a_st;
    o_st[1]    = b_st;
    o_stall[0] = a_stall;
    o_stall[1] = {8'd0, b_stall};
    o_flush[0] = a_flush;
    o_flush[1] = {8'd0, b_flush};
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int L   [2] = '{1, 3};
  int F   [2] = '{2, 2};
  int LIM [2] = '{65535, 255};
  int m_srem [2];   // stall cycles still owed after this one
  int m_frem [2];   // flush cycles still owed after this one
  bit m_busy [2];   // previous cycle saw memory busy
  int m_scnt [2];
  int m_fcnt [2];
  logic [5:0]  e_ctl;
  logic [31:0] e_addr;
  logic [1:0]  e_st;
  bit          inc_f;

  function automatic bit hz();
    return id_valid && ld && wen && (wa != 5'd0) &&
           (((r1 == wa) && (r1 != 5'd0)) || ((r2 == wa) && (r2 != 5'd0)));
  endfunction

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_srem[d] = 0; m_frem[d] = 0; m_busy[d] = 0; m_scnt[d] = 0; m_fcnt[d] = 0;
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        chk($sformatf("rst_ctl%0d", d), 64'(o_ctl[d]), 64'd0);
        chk($sformatf("rst_addr%0d", d), 64'(o_addr[d]), 64'd0);
        chk($sformatf("rst_state%0d", d), 64'(o_st[d]), 64'd0);
        chk($sformatf("rst_stall%0d", d), 64'(o_stall[d]), 64'd0);
        chk($sformatf("rst_flush%0d", d), 64'(o_flush[d]), 64'd0);
        m_srem[d] = 0; m_frem[d] = 0; m_busy[d] = 0; m_scnt[d] = 0; m_fcnt[d] = 0;
      end else begin
        e_st   = m_busy[d] ? 2'd3 : (m_srem[d] > 0) ? 2'd1 : (m_frem[d] > 0) ? 2'd2 : 2'd0;
        e_ctl  = 6'b000000;
        e_addr = 32'd0;
        inc_f  = 1'b0;
        if (busy) begin
          e_ctl = 6'b110010;
        end else if (jmp) begin
          e_ctl = 6'b001101; e_addr = jaddr; inc_f = 1'b1;
          m_frem[d] = F[d] - 1; m_srem[d] = 0;
        end else if (m_srem[d] > 0) begin
          e_ctl = 6'b110100; m_srem[d]--;
        end else if (m_frem[d] > 0) begin
          e_ctl = 6'b001100; m_frem[d]--;
        end else if (hz()) begin
          e_ctl = 6'b110100; m_srem[d] = L[d] - 1;
        end
        chk($sformatf("ctl%0d", d), 64'(o_ctl[d]), 64'(e_ctl));
        chk($sformatf("jaddr%0d", d), 64'(o_addr[d]), 64'(e_addr));
        chk($sformatf("state%0d", d), 64'(o_st[d]), 64'(e_st));
        chk($sformatf("stall_cnt%0d", d), 64'(o_stall[d]), 64'(m_scnt[d]));
        chk($sformatf("flush_cnt%0d", d), 64'(o_flush[d]), 64'(m_fcnt[d]));
        if (clr) begin
          m_scnt[d] = 0; m_fcnt[d] = 0;
        end else begin
          if (e_ctl[5] && m_scnt[d] < LIM[d]) m_scnt[d]++;
          if (inc_f && m_fcnt[d] < LIM[d]) m_fcnt[d]++;
        end
        m_busy[d] = busy;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input logic [4:0] a1, input logic [4:0] a2,
                       input bit l, input bit w, input logic [4:0] rd,
                       input bit j, input logic [31:0] ja, input bit b, input bit c);
    id_valid = v; r1 = a1; r2 = a2; ld = l; wen = w; wa = rd;
    jmp = j; jaddr = ja; busy = b; clr = c;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 32'd0, 0, 0);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int s0;

  initial begin
    idle();
    #1 rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("lit_reset_state", 64'(a_st), 64'd0);
    chk("lit_reset_stall", 64'(a_stall), 64'd0);

    // Load-use hazard on rs1
    drive(1, 5, 0, 1, 1, 5, 0, 32'd0, 0, 0);
    #1 chk("lit_hazard_hold", 64'({a_pch, a_ifh, a_bub}), 64'h7);
    tick(1); idle(); tick(4);
    chk("lit_stall_a", 64'(a_stall), 64'd1);
    chk("lit_stall_b", 64'(b_stall), 64'd3);

    // Non-hazards: rd=0, rs1=rs2=0, decode invalid
    drive(1, 0, 0, 1, 1, 0, 0, 32'd0, 0, 0); tick(1);
    drive(1, 0, 0, 1, 1, 5, 0, 32'd0, 0, 0); tick(1);
    drive(0, 5, 0, 1, 1, 5, 0, 32'd0, 0, 0); tick(1);
    idle(); tick(2);
    chk("lit_nohaz_stall_a", 64'(a_stall), 64'd1);
    chk("lit_nohaz_state_a", 64'(a_st), 64'd0);

    // Taken jump
    drive(0, 0, 0, 0, 0, 0, 1, 32'h80, 0, 0);
    #1 chk("lit_jump_addr", 64'(a_jaddr), 64'h80);
    tick(1); idle();
    #1 chk("lit_flush_2nd", 64'({a_iff, a_jen}), 64'b10);
    tick(3);
    chk("lit_flush_cnt", 64'(a_flush), 64'd1);

    // Hazard and jump together: jump wins
    drive(1, 5, 0, 1, 1, 5, 1, 32'h100, 0, 0);
    #1 chk("lit_jump_over_hazard", 64'({a_pch, a_jen}), 64'b01);
    tick(1); idle(); tick(3);

    // Busy masks the jump until it drops
    drive(1, 5, 0, 1, 1, 5, 1, 32'h200, 1, 0); tick(1);
    drive(0, 0, 0, 0, 0, 0, 1, 32'h200, 1, 0); tick(1);
    drive(0, 0, 0, 0, 0, 0, 1, 32'h200, 0, 0);
    #1 chk("lit_jump_after_busy", 64'(a_jaddr), 64'h200);
    tick(1); idle(); tick(3);

    // Jump aborting dut_b's load stall
    drive(1, 0, 7, 1, 1, 7, 0, 32'd0, 0, 0); tick(1);
    drive(0, 0, 0, 0, 0, 0, 1, 32'h300, 0, 0); tick(1);
    idle(); tick(3);

    // Busy during the second stall cycle of dut_b: 1 + 4 + 2 hold cycles
    s0 = int'(b_stall);
    drive(1, 5, 0, 1, 1, 5, 0, 32'd0, 0, 0); tick(1);
    drive(0, 0, 0, 0, 0, 0, 0, 32'd0, 1, 0); tick(4);
    idle(); tick(4);
    chk("lit_busy_stall_b", 64'(int'(b_stall) - s0), 64'd7);
    chk("lit_busy_state_b", 64'(b_st), 64'd0);

    // Counter clear, then clear together with an increment
    drive(0, 0, 0, 0, 0, 0, 0, 32'd0, 0, 1); tick(1);
    chk("lit_clr_a", 64'(a_stall), 64'd0);
    chk("lit_clr_flush_a", 64'(a_flush), 64'd0);
    drive(1, 5, 0, 1, 1, 5, 0, 32'd0, 0, 1); tick(1);
    chk("lit_clr_inc_a", 64'(a_stall), 64'd0);
    chk("lit_clr_inc_b", 64'(b_stall), 64'd0);
    idle(); tick(3);

    // Saturate dut_b's 8-bit stall counter
    drive(0, 0, 0, 0, 0, 0, 0, 32'd0, 1, 0); tick(260);
    chk("lit_sat_b", 64'(b_stall), 64'hFF);
    tick(3);
    chk("lit_sat_hold_b", 64'(b_stall), 64'hFF);
    idle(); tick(2);

    // Asynchronous reset in the middle of a flush
    drive(0, 0, 0, 0, 0, 0, 1, 32'h400, 0, 0); tick(1);
    idle(); #2;
    drive(1, 5, 0, 1, 1, 5, 1, 32'h500, 1, 0);
    rst_n = 1'b0;
    #1;
    chk("lit_arst_state_a", 64'(a_st), 64'd0);
    chk("lit_arst_ctl_a", 64'(o_ctl[0]), 64'd0);
    chk("lit_arst_addr_a", 64'(a_jaddr), 64'd0);
    chk("lit_arst_ctl_b", 64'(o_ctl[1]), 64'd0);
    tick(2);
    idle();
    rst_n = 1'b1;
    tick(3);
    chk("lit_post_rst_jen", 64'(a_jen), 64'd0);
    chk("lit_post_rst_state", 64'(a_st), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
